// File: rtl/iter_mul_16b_pkg.sv
// Shared definitions for the iterative 16-bit multiplier: FSM encodings and iteration count.
package iter_mul_16b_pkg;

    localparam int MUL_ITERS = 16;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_CALC = 2'd1,
        STATE_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_16b_rtl.sv
// Behavioural 16-bit adder, pin-compatible with the gate-level carry-select adder.
module adder_16b_rtl (
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic        cin,
    output logic        cout,
    output logic [15:0] sum
);

    assign {cout, sum} = {1'b0, in0} + {1'b0, in1} + {16'd0, cin};

endmodule

// File: rtl/iter_mul_16b.sv
// Iterative shift-and-add multiplier returning the low 16 bits of in0*in1 after 16 fixed iterations.
module iter_mul_16b
    import iter_mul_16b_pkg::*;
#(
    parameter int NBITS = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [NBITS-1:0] prod
);

    // Handshake: a transfer happens on a rising edge where val and rdy are both 1;
    // val never waits on rdy, and rdy/val are registered FSM outputs.

    state_t           state;
    logic [NBITS-1:0] a_reg;
    logic [NBITS-1:0] b_reg;
    logic [NBITS-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [NBITS-1:0] sum;
    logic             adder_cout_unused;

    adder_16b_rtl u_adder (
        .in0  (acc),
        .in1  (a_reg),
        .cin  (1'b0),
        .cout (adder_cout_unused),
        .sum  (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= STATE_IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            acc         <= '0;
            cnt         <= '0;
            istream_rdy <= 1'b1;
            ostream_val <= 1'b0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (istream_val && istream_rdy) begin
                        a_reg       <= in0;
                        b_reg       <= in1;
                        acc         <= '0;
                        cnt         <= '0;
                        istream_rdy <= 1'b0;
                        state       <= STATE_CALC;
                    end
                end
                STATE_CALC: begin
                    if (b_reg[0]) begin
                        acc <= sum;
                    end
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    // Always run the full iteration count so latency is operand independent.
                    if (cnt == CNT_W'(MUL_ITERS - 1)) begin
                        ostream_val <= 1'b1;
                        state       <= STATE_DONE;
                    end
                end
                STATE_DONE: begin
                    if (ostream_val && ostream_rdy) begin
                        ostream_val <= 1'b0;
                        istream_rdy <= 1'b1;
                        state       <= STATE_IDLE;
                    end
                end
                default: begin
                    ostream_val <= 1'b0;
                    istream_rdy <= 1'b1;
                    state       <= STATE_IDLE;
                end
            endcase
        end
    end

    assign prod = acc;

endmodule

// File: tb/tb_iter_mul_16b.sv
// Self-checking bench for iter_mul_16b: directed cases plus randomized traffic against a scoreboard.
module tb_iter_mul_16b;

    logic        clk;
    logic        rst;
    logic        istream_val;
    logic        istream_rdy;
    logic [15:0] in0;
    logic [15:0] in1;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [15:0] prod;

    logic [15:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    logic        rdy_random;

    iter_mul_16b dut (
        .clk         (clk),
        .rst         (rst),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .in0         (in0),
        .in1         (in1),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .prod        (prod)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: low 16 bits of the full unsigned product.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        return p[15:0];
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, expv, $time);
        end
    endtask

    // Driver: present operands after a posedge, hold until accepted.
    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int  n;
        logic done;
        @(posedge clk); #1;
        istream_val = 1'b1;
        in0 = a;
        in1 = b;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (istream_rdy) begin
                done = 1'b1;
                exp_q.push_back(ref_mul(a, b));
            end else begin
                n++;
                if (n > 200) begin
                    done = 1'b1;
                    check("accept_timeout", 16'd0, 16'd1);
                end
            end
        end
        @(posedge clk); #1;
        istream_val = 1'b0;
        in0 = 16'($urandom);
        in1 = 16'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 16'(exp_q.size()), 16'd0);
    endtask

    // Monitor: pop and compare on every result handshake.
    always @(negedge clk) begin
        if (!rst && ostream_val === 1'b1 && ostream_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got=%h expected=none at %0t", prod, $time);
            end else begin
                check("prod", prod, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        if (rdy_random) begin
            #1 ostream_rdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        int n;
        logic [15:0] a;
        logic [15:0] b;
        n_checks    = 0;
        n_fail      = 0;
        rdy_random  = 1'b0;
        rst         = 1'b1;
        istream_val = 1'b0;
        ostream_rdy = 1'b0;
        in0         = '0;
        in1         = '0;
        #1;
        check("reset_prod", prod, 16'd0);
        check("reset_oval", 16'(ostream_val), 16'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_irdy", 16'(istream_rdy), 16'd1);
            check("idle_oval", 16'(ostream_val), 16'd0);
            check("idle_prod", prod, 16'd0);
        end

        // Basic with latency measurement
        ostream_rdy = 1'b1;
        send(16'd3, 16'd5);
        n = 0;
        while (ostream_val !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", 16'(n), 16'd17);
        @(negedge clk);
        check("irdy_after", 16'(istream_rdy), 16'd1);

        // Wrap and bounds
        send(16'hFFFF, 16'hFFFF);
        wait_drain();
        send(16'h0100, 16'h0100);
        wait_drain();
        send(16'h0000, 16'h1234);
        wait_drain();

        // Backpressure
        @(posedge clk); #1 ostream_rdy = 1'b0;
        send(16'd7, 16'd6);
        n = 0;
        while (ostream_val !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", 16'(n), 16'd17);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_prod", prod, 16'd42);
            check("bp_hold_oval", 16'(ostream_val), 16'd1);
            check("bp_irdy", 16'(istream_rdy), 16'd0);
        end
        @(posedge clk); #1 ostream_rdy = 1'b1;
        wait_drain();
        @(negedge clk);
        check("bp_back_idle", 16'(istream_rdy), 16'd1);

        // Reset mid-operation
        send(16'd9, 16'd9);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_oval", 16'(ostream_val), 16'd0);
        check("midrst_prod", prod, 16'd0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_irdy", 16'(istream_rdy), 16'd1);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check("midrst_no_oval", 16'(ostream_val), 16'd0);
        end
        send(16'd2, 16'd3);
        wait_drain();

        // Random back-to-back with stalls
        rdy_random = 1'b1;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0: a = 16'hFFFF;
                1: a = 16'h0000;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: b = 16'hFFFF;
                1: b = 16'h0001;
                default: b = 16'($urandom);
            endcase
            send(a, b);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        @(posedge clk);
        rdy_random = 1'b0;
        #2 ostream_rdy = 1'b1;
        wait_drain();
        repeat (5) @(negedge clk);
        check("final_queue", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_mul_16b.md
Name: iter_mul_16b

Overview:
- Iterative shift-and-add multiplier that produces the low 16 bits of in0*in1, i.e. the product modulo 2^16.
- Sits in front of the 16-bit adder datapath.
- Each iteration feeds the accumulator and shifted multiplicand into a 16-bit adder, then registers the sum.
- Latency-insensitive val/rdy streams on both sides. Used as the multi-cycle mul unit of the processor datapath.

Parameters:
- NBITS, 16, operand/result width; only 16 is supported and verified.
- CNT_W, 5, width of the iteration counter; must hold NBITS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset; forces all state to reset values immediately.
- istream_val  input  1  request operands valid.
- istream_rdy  output  1  unit can accept operands.
- in0  input  16  multiplicand.
- in1  input  16  multiplier.
- ostream_val  output  1  result valid.
- ostream_rdy  input  1  consumer can accept result.
- prod  output  16  low 16 bits of in0*in1.

Behaviour:
- State machine with three states.
  - IDLE: istream_rdy=1, ostream_val=0.
  - CALC: both handshake signals 0.
  - DONE: ostream_val=1, istream_rdy=0.
- Reset (async, rst=1):
  - state=IDLE, a_reg=0, b_reg=0, acc=0, cnt=0.
  - Outputs: istream_rdy=1 (once out of reset), ostream_val=0, prod=0.
- Reset asserted mid-CALC or mid-DONE: the operation and result are discarded; no ostream_val follows.
- IDLE -> CALC when istream_val & istream_rdy on a rising edge.
  - Load a_reg=in0, b_reg=in1, acc=0, cnt=0.
  - istream_val=0 in IDLE: hold state, registers unchanged.
- CALC, each cycle:
  - If b_reg[0]=1: acc <= acc + a_reg through the 16-bit adder, with cin=0 and cout ignored, so the sum wraps modulo 2^16.
  - a_reg <= a_reg << 1 (zero fill); b_reg <= b_reg >> 1 (zero fill); cnt <= cnt+1.
  - After the cycle with cnt==15, go to DONE.
- Exactly 16 CALC cycles for every operand pair; no early exit. Fixed latency makes bench timing deterministic.
- Latency: operand handshake at edge T, ostream_val=1 in the cycle after edge T+16, i.e. 17 cycles from accept to result-valid.
- prod is driven directly from acc.
  - acc is stable throughout DONE.
  - In IDLE and CALC prod is don't-care for consumers, but prod must not be X after reset.
- DONE -> IDLE on ostream_val & ostream_rdy. ostream_rdy=0 holds DONE and prod indefinitely.
- No overlap: the next operands are accepted no earlier than the cycle after the result handshake, since istream_rdy is 0 in DONE.
- in0/in1 changes after the accept edge have no effect on the result.
- Signedness: the low 16 bits are identical for signed and unsigned operands; no sign handling needed.
- Illegal/unused state encoding recovers to IDLE on the next edge.

Decomposition:
- Shared package/header holds:
  - state encodings STATE_IDLE=2'd0, STATE_CALC=2'd1, STATE_DONE=2'd2;
  - constant MUL_ITERS=16.
- One natural sub-module: adder_16b_rtl (in0, in1, cin, cout, sum), instantiated once for the acc+a_reg add.
  - It is pin-compatible with the gate-level carry-select adder, so either can be swapped in.
- Control FSM and datapath registers stay in the top module; no further split.

Test Plan:
- Reset then idle: rst pulse, no valid -> istream_rdy=1, ostream_val=0, prod=0 for 20 cycles.
- Basic: in0=3, in1=5, ostream_rdy=1 -> ostream_val rises exactly 17 cycles after accept, prod=15; istream_rdy=1 the following cycle.
- Wrap and bounds:
  - in0=0xFFFF, in1=0xFFFF -> prod=0x0001;
  - in0=0x0100, in1=0x0100 -> prod=0x0000;
  - in0=0, in1=0x1234 -> prod=0.
- Backpressure: in0=7, in1=6, ostream_rdy=0 for 10 cycles after result -> prod holds 42, istream_rdy=0 throughout; release ostream_rdy -> handshake, back to IDLE.
- Reset mid-operation: accept in0=9, in1=9, assert rst at cycle 8 of CALC -> immediately IDLE, no ostream_val. Next request in0=2, in1=3 -> prod=6.
- Random back-to-back: 200 random pairs with random val/rdy stalls -> each prod equals (in0*in1) & 0xFFFF, in order, none dropped or duplicated.
